// File: rtl/dmem_arbiter.sv
// dmem_arbiter: serializes two req/ack requesters onto the single-port data memory.
// Define DMEM_ARB_RR_EN for round-robin IDLE tie-breaks; otherwise port 0 has fixed priority.
module dmem_arbiter #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_ack,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_ack,
    output logic [DW-1:0] m1_rdata,
    output logic [AW-1:0] mem_address,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_memread,
    output logic          mem_memwrite,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic [1:0] {StIdle, StIssue, StDone} state_e;

    state_e        state;
    logic          gnt;
    logic          we_q;
    logic          idle_win;
    logic          nxt_own;
    logic          nxt_valid;
    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;
`ifdef DMEM_ARB_RR_EN
    logic          last;
`endif

    always_comb begin
`ifdef DMEM_ARB_RR_EN
        idle_win = (m0_req && m1_req) ? ~last : ~m0_req;
`else
        idle_win = ~m0_req;
`endif
        // From DONE only the other port may be granted; the just-acked req is ignored.
        nxt_own   = (state == StDone) ? ~gnt : idle_win;
        nxt_valid = (state == StDone) ? (gnt ? m0_req : m1_req)
                                      : ((state == StIdle) && (m0_req || m1_req));
        sel_we    = nxt_own ? m1_we    : m0_we;
        sel_addr  = nxt_own ? m1_addr  : m0_addr;
        sel_wdata = nxt_own ? m1_wdata : m0_wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= StIdle;
            gnt          <= 1'b0;
            we_q         <= 1'b0;
            mem_address  <= '0;
            mem_wdata    <= '0;
            mem_memread  <= 1'b0;
            mem_memwrite <= 1'b0;
            m0_ack       <= 1'b0;
            m1_ack       <= 1'b0;
`ifdef DMEM_ARB_RR_EN
            last         <= 1'b1;
`endif
        end else begin
            mem_memread  <= 1'b0;
            mem_memwrite <= 1'b0;
            m0_ack       <= 1'b0;
            m1_ack       <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (nxt_valid) state <= StIssue;
                end
                StIssue: begin
                    state  <= StDone;
                    m0_ack <= ~gnt;
                    m1_ack <= gnt;
                end
                StDone: begin
`ifdef DMEM_ARB_RR_EN
                    last <= gnt;
`endif
                    state <= nxt_valid ? StIssue : StIdle;
                end
                default: state <= StIdle;
            endcase
            if (nxt_valid) begin
                gnt          <= nxt_own;
                we_q         <= sel_we;
                mem_address  <= sel_addr;
                mem_wdata    <= sel_wdata;
                mem_memread  <= ~sel_we;
                mem_memwrite <= sel_we;
            end
        end
    end

    // Memory read data is registered by the memory itself, so it is forwarded during DONE.
    assign m0_rdata = (m0_ack && !we_q) ? mem_rdata : '0;
    assign m1_rdata = (m1_ack && !we_q) ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus random two-port traffic
// checked against a transaction-level model of the arbitration rules and a 64-word memory.
module tb_dmem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
`ifdef DMEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
    logic [AW-1:0] m0_addr = '0, m1_addr = '0;
    logic [DW-1:0] m0_wdata = '0, m1_wdata = '0;
    logic          m0_ack, m1_ack, mem_memread, mem_memwrite;
    logic [DW-1:0] m0_rdata, m1_rdata, mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic [AW-1:0] mem_address;

    int n_checks = 0;
    int n_errors = 0;
    int tcyc = 0;

    dmem_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_rdata(m1_rdata),
        .mem_address(mem_address), .mem_wdata(mem_wdata),
        .mem_memread(mem_memread), .mem_memwrite(mem_memwrite), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) tcyc <= tcyc + 1;

    function automatic logic [31:0] init_word(input int i);
        return 32'hC0DE_0000 ^ (32'(i) * 32'h9E37_79B9);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, tcyc);
        end
    endtask

    // Data memory: 64 words, synchronous write, registered read.
    logic [31:0] mem [64];
    logic        mem_init = 1'b0;
    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
            mem_init <= 1'b1;
        end else begin
            if (mem_memwrite) mem[mem_address[5:0]] <= mem_wdata;
            if (mem_memread) mem_rdata <= mem[mem_address[5:0]];
        end
    end

    // Reference model: at most one transaction in flight; grant decided in a free cycle,
    // memory access the cycle after, ack the cycle after that.
    logic [31:0] refmem [64];
    bit          ref_init = 1'b0;
    bit          cur_v = 1'b0, cur_p = 1'b0, cur_we = 1'b0, last_owner = 1'b1;
    logic [31:0] cur_addr = '0, cur_wdata = '0;
    int          cur_issue = 0, mon_cyc = 0;

    always @(negedge clk) begin
        bit          exp_issue, exp_ack, gv, g;
        logic [31:0] exp_rd0, exp_rd1;
        if (!ref_init) begin
            for (int i = 0; i < 64; i++) refmem[i] = init_word(i);
            ref_init = 1'b1;
        end
        if (!rst_n) begin
            cur_v = 1'b0;
            last_owner = 1'b1;
            chk("rst_acks", 32'({m1_ack, m0_ack}), 32'd0);
            chk("rst_rdata0", m0_rdata, 32'd0);
            chk("rst_rdata1", m1_rdata, 32'd0);
            chk("rst_rdwr", 32'({mem_memread, mem_memwrite}), 32'd0);
            chk("rst_addr", mem_address, 32'd0);
            chk("rst_wdata", mem_wdata, 32'd0);
        end else begin
            mon_cyc++;
            exp_issue = cur_v && (mon_cyc == cur_issue);
            exp_ack   = cur_v && (mon_cyc == cur_issue + 1);
            exp_rd0   = (exp_ack && !cur_p && !cur_we) ? refmem[cur_addr[5:0]] : 32'd0;
            exp_rd1   = (exp_ack && cur_p && !cur_we) ? refmem[cur_addr[5:0]] : 32'd0;
            chk("m0_ack", 32'(m0_ack), 32'(exp_ack && !cur_p));
            chk("m1_ack", 32'(m1_ack), 32'(exp_ack && cur_p));
            chk("m0_rdata", m0_rdata, exp_rd0);
            chk("m1_rdata", m1_rdata, exp_rd1);
            chk("memread", 32'(mem_memread), 32'(exp_issue && !cur_we));
            chk("memwrite", 32'(mem_memwrite), 32'(exp_issue && cur_we));
            chk("inv_both_ack", 32'(m0_ack && m1_ack), 32'd0);
            if (exp_issue) begin
                chk("mem_address", mem_address, cur_addr);
                if (cur_we) chk("mem_wdata", mem_wdata, cur_wdata);
            end
            gv = 1'b0;
            g  = 1'b0;
            if (exp_ack) begin
                if (cur_we) refmem[cur_addr[5:0]] = cur_wdata;
                last_owner = cur_p;
                cur_v = 1'b0;
                if (cur_p ? m0_req : m1_req) begin
                    gv = 1'b1;
                    g  = ~cur_p;
                end
            end else if (!cur_v) begin
                if (m0_req && m1_req) begin
                    gv = 1'b1;
                    g  = RR ? ~last_owner : 1'b0;
                end else if (m0_req || m1_req) begin
                    gv = 1'b1;
                    g  = m1_req;
                end
            end
            if (gv) begin
                cur_v     = 1'b1;
                cur_p     = g;
                cur_we    = g ? m1_we : m0_we;
                cur_addr  = g ? m1_addr : m0_addr;
                cur_wdata = g ? m1_wdata : m0_wdata;
                cur_issue = mon_cyc + 1;
            end
        end
    end

    task automatic drive(input bit p, input bit req, input bit we, input logic [31:0] addr,
                         input logic [31:0] wdata);
        if (p) begin
            m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = wdata;
        end else begin
            m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = wdata;
        end
    endtask

    task automatic do_txn(input bit p, input bit we, input logic [31:0] addr,
                          input logic [31:0] wdata, output int lat, output logic [31:0] rd,
                          output int ack_cyc);
        int  start;
        bit  got;
        @(posedge clk);
        #1;
        drive(p, 1'b1, we, addr, wdata);
        start = tcyc;
        got = 1'b0;
        ack_cyc = -1;
        rd = '0;
        for (int k = 0; k < 12 && !got; k++) begin
            @(negedge clk);
            if (p ? m1_ack : m0_ack) begin
                got = 1'b1;
                ack_cyc = tcyc;
                rd = p ? m1_rdata : m0_rdata;
            end
        end
        chk("ack_seen", 32'(got), 32'd1);
        lat = ack_cyc - start;
        @(posedge clk);
        #1;
        drive(p, 1'b0, we, addr, wdata);
    endtask

    task automatic rand_drive(input bit p, input int n, input int pct);
        bit seen = 1'b0;
        bit req = 1'b0;
        bit we = 1'b0;
        logic [31:0] addr = '0, wdata = '0;
        repeat (n) begin
            @(posedge clk);
            #1;
            if (seen || !req) begin
                req = ($urandom_range(0, 99) < pct);
                we = $urandom_range(0, 1) == 1;
                addr = $urandom_range(0, 63);
                wdata = $urandom;
            end
            drive(p, req, we, addr, wdata);
            @(negedge clk);
            seen = p ? m1_ack : m0_ack;
        end
        @(posedge clk);
        #1;
        drive(p, 1'b0, 1'b0, '0, '0);
    endtask

    initial begin
        int          l0, l1, t0, t1;
        logic [31:0] rd0, rd1;

        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;

        // Simultaneous requests from reset: port 0 first, port 1 handed off from DONE.
        fork
            do_txn(1'b0, 1'b0, 32'd1, 32'd0, l0, rd0, t0);
            do_txn(1'b1, 1'b1, 32'd2, 32'h11, l1, rd1, t1);
        join
        chk("tie_gap", 32'(t1 - t0), 32'd2);
        chk("tie_lat0", 32'(l0), 32'd2);
        chk("tie_rd0", rd0, init_word(1));

        do_txn(1'b0, 1'b1, 32'd5, 32'hDEADBEEF, l0, rd0, t0);
        chk("wr5_lat", 32'(l0), 32'd2);
        chk("wr5_rdata", rd0, 32'd0);
        do_txn(1'b0, 1'b0, 32'd5, 32'd0, l0, rd0, t0);
        chk("rd5_lat", 32'(l0), 32'd2);
        chk("rd5_rdata", rd0, 32'hDEADBEEF);

        do_txn(1'b1, 1'b0, 32'd63, 32'd0, l1, rd1, t1);
        chk("rd63_rdata", rd1, init_word(63));

        // Reset during the ISSUE cycle of a write must drop that write.
        @(posedge clk);
        #1 drive(1'b0, 1'b1, 1'b1, 32'd7, 32'h12345678);
        @(posedge clk);
        #2 chk("pre_rst_wr", 32'(mem_memwrite), 32'd1);
        #1 rst_n = 1'b0;
        #1 chk("rst_async_wr", 32'(mem_memwrite), 32'd0);
        chk("rst_async_addr", mem_address, 32'd0);
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
        do_txn(1'b0, 1'b0, 32'd7, 32'd0, l0, rd0, t0);
        chk("rd7_after_rst", rd0, init_word(7));

        fork
            rand_drive(1'b0, 400, 30);
            rand_drive(1'b1, 400, 30);
        join
        fork
            rand_drive(1'b0, 400, 90);
            rand_drive(1'b1, 400, 90);
        join
        repeat (8) @(posedge clk);
        @(negedge clk);
        chk("drained", 32'(cur_v), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single-port data memory between two requesters: port 0 is the core load/store path and port 1 is the debug/DMA loader. It serializes requests with a req/ack handshake and drives the memory's address, wdata, memread and memwrite pins for exactly one cycle per transaction. It returns the memory's registered read data to the winning requester. It sits between the requesters and the data memory, and is the only driver of the memory control pins.

## Interface
- AW, 32, address width (passed to memory unchanged)
- DW, 32, data width
- clk  in  1  rising-edge clock shared with data memory
- rst_n  in  1  asynchronous active-low reset
- m0_req, m1_req  in  1  transaction request; held until ack
- m0_we, m1_we  in  1  1 = write, 0 = read; stable while req
- m0_addr, m1_addr  in  AW  word address; stable while req
- m0_wdata, m1_wdata  in  DW  write data; stable while req
- m0_ack, m1_ack  out  1  one-cycle completion pulse
- m0_rdata, m1_rdata  out  DW  read data, valid only while own ack=1, else 0
- mem_address  out  AW  to memory address
- mem_wdata  out  DW  to memory wdata
- mem_memread  out  1  to memory memread
- mem_memwrite  out  1  to memory memwrite
- mem_rdata  in  DW  from memory rdata (updates on clk edge when memread=1)

## Operation
- FSM states: IDLE, ISSUE, DONE. Registers: state, gnt (1 bit, current owner), last (1 bit, previous owner), latched we/addr/wdata.
- IDLE: if any req, pick winner by policy (see Configuration), latch its we/addr/wdata into mem_* registers, gnt<=winner, go ISSUE; else stay.
- ISSUE: mem_memread = ~we, mem_memwrite = we (exactly one high); memory samples at the edge ending ISSUE. Go DONE.
- DONE: ack for gnt = 1; rdata for gnt = mem_rdata (read) or 0 (write); mem_memread = mem_memwrite = 0; last<=gnt.
  - If other port's req = 1: grant it directly, latch its fields, go ISSUE (back-to-back, no IDLE bubble).
  - Else go IDLE. The just-acked port is never re-granted from DONE; its held req is ignored that cycle.
- mem_address/mem_wdata hold last latched values outside ISSUE; memread/memwrite are 0 outside ISSUE.
- Requester dropping req before ack: undefined usage; arbiter completes the latched transaction and still pulses ack.
- Addresses are not range-checked; the memory's 64-word depth is the memory's concern.

## Timing
- Reset (async, immediate): state=IDLE, gnt=0, last=1, all mem_* outputs 0, both ack 0, both rdata 0.
- Reset asserted during ISSUE clears memwrite before the next edge; that write is dropped.
- Latency: req sampled in IDLE at cycle N -> ISSUE cycle N+1 -> ack/rdata in cycle N+2.
- Throughput: alternating requesters, one transaction every 2 cycles; single requester, one every 3 cycles.
- ack is never high on both ports in the same cycle; at most one of memread/memwrite is high in any cycle.
- Simultaneous req in IDLE: resolved by policy; loser waits, and is granted from DONE of the winner.

## Configuration
- DMEM_ARB_RR_EN defined: round-robin. In IDLE with both reqs, grant the port != last. From reset, port 0 wins first.
- Undefined: fixed priority. In IDLE, port 0 always wins over port 1. The DONE handoff to the other port is unchanged, so port 1 cannot starve while port 0 releases between transactions.

## Test plan
- Reset: hold rst_n=0 mid-transaction -> all outputs 0, state IDLE; release, no spurious memwrite.
- Port 0 write addr 5 data 0xDEADBEEF, then port 0 read addr 5 -> memwrite high 1 cycle with addr 5; m0_ack at cycle N+2; read ack returns m0_rdata=0xDEADBEEF.
- Both req same cycle from reset (port 0 read addr 1, port 1 write addr 2 data 0x11) -> port 0 acked first, then port 1 ISSUE directly from DONE; ack two cycles apart.
- RR_EN defined, both ports requesting continuously for 6 transactions -> grants strictly alternate 0,1,0,1,...; without macro, with port 0 re-requesting only from IDLE, it wins every IDLE tie.
- Port 1 read addr 63 with m0 idle -> m1_rdata = mem[63] only in ack cycle; m0_rdata stays 0 throughout.
- Invariant checks every cycle: never both acks, never memread and memwrite together, memread/memwrite only in ISSUE.
